pwm_multichannel: RTL



---
 rtl/pwm_pkg.sv | 11 +
 rtl/pwm_prescaler.sv | 27 ++
 rtl/pwm_multichannel.sv | 89 ++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared defaults and servo timing constants for the multichannel PWM block.
package pwm_pkg;
    localparam int CNT_W_DEF = 16;
    localparam int PRE_W_DEF = 8;

    // 50 MHz clk -> 1 us tick, 20 ms frame, 1..2 ms pulse
    localparam int SERVO_TICK_PRESCALE_50MHZ = 49;
    localparam int SERVO_PERIOD_20MS         = 19999;
    localparam int SERVO_MIN                 = 1000;
    localparam int SERVO_MAX                 = 2000;
endpackage

// File: rtl/pwm_prescaler.sv
// Clock divider: one tick every prescale+1 clocks while enabled.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PRE_W = PRE_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [PRE_W-1:0] prescale,
    output logic             tick
);

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;

    // prescale is used live; shrinking it below pre_cnt wraps through 2^PRE_W
    always_comb begin
        tick      = enable && (pre_cnt_q == prescale);
        pre_cnt_d = (!enable || tick) ? '0 : pre_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) pre_cnt_q <= '0;
        else     pre_cnt_q <= pre_cnt_d;
    end

endmodule

// File: rtl/pwm_multichannel.sv
// N-channel PWM with shared prescaler/period counter and double-buffered
// period/duty that switch over only at a frame boundary.
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int                  CHANNELS = 4,
    parameter int                  CNT_W    = CNT_W_DEF,
    parameter int                  PRE_W    = PRE_W_DEF,
    parameter logic [CHANNELS-1:0] IDLE_LVL = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [PRE_W-1:0]          prescale,
    input  logic [CNT_W-1:0]          period,
    input  logic [CHANNELS*CNT_W-1:0] duty,
    input  logic                      load,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      frame_start,
    output logic                      pending
);

    logic                               tick, wrap, apply;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic [CNT_W-1:0]                   period_act_q, period_act_d;
    logic [CNT_W-1:0]                   period_sh_q, period_sh_d;
    logic [CHANNELS-1:0][CNT_W-1:0]     duty_act_q, duty_act_d;
    logic [CHANNELS-1:0][CNT_W-1:0]     duty_sh_q, duty_sh_d;
    logic                               pending_q, pending_d;
    logic                               frame_start_q, frame_start_d;
    logic [CHANNELS-1:0]                pwm_q, pwm_d;

    pwm_prescaler #(.PRE_W(PRE_W)) u_pre (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .prescale (prescale),
        .tick     (tick)
    );

    always_comb begin
        // >= rather than == so an out-of-range count still wraps
        wrap  = (cnt_q >= period_act_q);
        apply = pending_q && (!enable || (tick && wrap));

        cnt_d = cnt_q;
        if (!enable)   cnt_d = '0;
        else if (tick) cnt_d = wrap ? '0 : cnt_q + 1'b1;

        period_act_d  = apply ? period_sh_q : period_act_q;
        duty_act_d    = apply ? duty_sh_q   : duty_act_q;
        period_sh_d   = load  ? period      : period_sh_q;
        duty_sh_d     = load  ? duty        : duty_sh_q;
        // a load on the apply edge stays pending for the next boundary
        pending_d     = load || (pending_q && !apply);
        frame_start_d = tick && wrap;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign pwm_d[i] = enable ? ((cnt_q < duty_act_q[i]) ^ IDLE_LVL[i]) : IDLE_LVL[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            period_act_q  <= '0;
            period_sh_q   <= '0;
            duty_act_q    <= '0;
            duty_sh_q     <= '0;
            pending_q     <= 1'b0;
            frame_start_q <= 1'b0;
            pwm_q         <= IDLE_LVL;
        end else begin
            cnt_q         <= cnt_d;
            period_act_q  <= period_act_d;
            period_sh_q   <= period_sh_d;
            duty_act_q    <= duty_act_d;
            duty_sh_q     <= duty_sh_d;
            pending_q     <= pending_d;
            frame_start_q <= frame_start_d;
            pwm_q         <= pwm_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign frame_start = frame_start_q;
    assign pending     = pending_q;

endmodule
